// File: rtl/mem_stage.sv
// Memory stage: takes a load/store from the ALU stage, runs it on the data-memory
// req/gnt/rvalid port and returns formatted write-back data to the register file.
package mem_stage_pkg;
    typedef enum logic {BYTE = 1'b0, WORD = 1'b1} access_size_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REGISTER_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic                      reg_wr_en_i,
    input  access_size_t              access_size_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [REGISTER_WIDTH-1:0] rd_i,
    output logic                      stall_o,
    output logic                      dmem_req_o,
    output logic                      dmem_we_o,
    output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
    output logic [3:0]                dmem_be_o,
    output logic [DATA_WIDTH-1:0]     dmem_wdata_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata_i,
    output logic                      wb_valid_o,
    output logic                      wb_reg_wr_en_o,
    output logic [REGISTER_WIDTH-1:0] wb_rd_o,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    output logic                      misaligned_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    logic [1:0]                state;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    access_size_t              req_size;
    logic [REGISTER_WIDTH-1:0] req_rd;
    logic                      req_wr_en;
    logic                      req_is_load;

    logic                      accept;
    logic                      misaligned_req;
    logic                      in_req;
    logic [7:0]                rbyte;
    logic [DATA_WIDTH-1:0]     load_data;

    assign accept         = (state == StIdle) && valid_i && (is_load_i || is_store_i);
    assign misaligned_req = (access_size_i == WORD) && (addr_i[1:0] != 2'b00);
    assign in_req         = (state == StReq);

    assign stall_o      = (state != StIdle);
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req && !req_is_load;
    assign dmem_addr_o  = in_req ? {req_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    // Byte stores replicate the byte on every lane; the enables pick the target.
    assign dmem_wdata_o = !in_req          ? '0 :
                          (req_size == BYTE) ? {(DATA_WIDTH/8){req_wdata[7:0]}} : req_wdata;

    always_comb begin
        dmem_be_o = 4'b0000;
        if (in_req) begin
            if (req_is_load || (req_size == WORD)) begin
                dmem_be_o = 4'b1111;
            end else begin
                dmem_be_o = 4'b0001 << req_addr[1:0];
            end
        end
    end

    always_comb begin
        rbyte     = dmem_rdata_i[{req_addr[1:0], 3'b000} +: 8];
        load_data = (req_size == BYTE) ? {{(DATA_WIDTH-8){rbyte[7]}}, rbyte} : dmem_rdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= StIdle;
            req_addr       <= '0;
            req_wdata      <= '0;
            req_size       <= BYTE;
            req_rd         <= '0;
            req_wr_en      <= 1'b0;
            req_is_load    <= 1'b0;
            wb_valid_o     <= 1'b0;
            wb_reg_wr_en_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            misaligned_o   <= 1'b0;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_wr_en_o <= 1'b0;
            misaligned_o   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        req_addr    <= addr_i;
                        req_wdata   <= wdata_i;
                        req_size    <= access_size_i;
                        req_rd      <= rd_i;
                        req_wr_en   <= reg_wr_en_i;
                        req_is_load <= is_load_i;
                        // Misaligned words never reach memory; report and stay idle.
                        if (misaligned_req) begin
                            wb_valid_o   <= 1'b1;
                            misaligned_o <= 1'b1;
                            wb_rd_o      <= rd_i;
                        end else begin
                            state <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (dmem_gnt_i) begin
                        if (req_is_load) begin
                            state <= StWait;
                        end else begin
                            state      <= StIdle;
                            wb_valid_o <= 1'b1;
                            wb_rd_o    <= req_rd;
                        end
                    end
                end
                StWait: begin
                    if (dmem_rvalid_i) begin
                        state          <= StIdle;
                        wb_valid_o     <= 1'b1;
                        wb_reg_wr_en_o <= req_wr_en;
                        wb_rd_o        <= req_rd;
                        wb_data_o      <= load_data;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: drives ALU requests, models the memory handshake and
// checks write-back pulses against a queue of expected results.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         valid_i, is_load_i, is_store_i, reg_wr_en_i;
    access_size_t access_size_i;
    logic [31:0]  addr_i, wdata_i;
    logic [4:0]   rd_i;
    logic         stall_o, dmem_req_o, dmem_we_o;
    logic [31:0]  dmem_addr_o, dmem_wdata_o;
    logic [3:0]   dmem_be_o;
    logic         dmem_gnt_i, dmem_rvalid_i;
    logic [31:0]  dmem_rdata_i;
    logic         wb_valid_o, wb_reg_wr_en_o, misaligned_o;
    logic [4:0]   wb_rd_o;
    logic [31:0]  wb_data_o;

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .REGISTER_WIDTH(5)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_ni),
        .valid_i(valid_i),
        .is_load_i(is_load_i),
        .is_store_i(is_store_i),
        .reg_wr_en_i(reg_wr_en_i),
        .access_size_i(access_size_i),
        .addr_i(addr_i),
        .wdata_i(wdata_i),
        .rd_i(rd_i),
        .stall_o(stall_o),
        .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o),
        .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o),
        .wb_reg_wr_en_o(wb_reg_wr_en_o),
        .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o),
        .misaligned_o(misaligned_o)
    );

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
    } wb_t;

    wb_t         sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned n_wb = 0;
    int unsigned n_wb_exp = 0;
    logic [31:0] exp_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(access_size_t sz, logic [31:0] a, logic [31:0] d);
        logic [31:0] sh;
        if (sz == WORD) return d;
        sh = d >> (8 * a[1:0]);
        return {{24{sh[7]}}, sh[7:0]};
    endfunction

    // Write-back monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        wb_t e;
        if (misaligned_o) check("mis_without_wb", wb_valid_o, 1'b1);
        if (wb_valid_o) begin
            n_wb++;
            if (sb.size() == 0) begin
                check("wb_unexpected", wb_valid_o, 1'b0);
            end else begin
                e = sb.pop_front();
                check("wb_reg_wr_en", wb_reg_wr_en_o, e.wr_en);
                if (e.wr_en) check("wb_rd", wb_rd_o, e.rd);
                check("wb_data", wb_data_o, e.data);
                check("wb_misaligned", misaligned_o, e.mis);
            end
        end
    end

    task automatic issue(input bit ld, input bit st, input access_size_t sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                         input bit wr, input logic [31:0] rdata,
                         output logic [31:0] e_addr, output logic [31:0] e_be,
                         output logic [31:0] e_wdata);
        wb_t e;
        valid_i = 1'b1; is_load_i = ld; is_store_i = st; access_size_i = sz;
        addr_i = a; wdata_i = wd; rd_i = r; reg_wr_en_i = wr;
        e_addr  = {a[31:2], 2'b00};
        e_wdata = (sz == BYTE) ? {4{wd[7:0]}} : wd;
        if (ld || sz == WORD) e_be = 32'hF;
        else case (a[1:0])
            2'd0: e_be = 32'h1;
            2'd1: e_be = 32'h2;
            2'd2: e_be = 32'h4;
            default: e_be = 32'h8;
        endcase
        e.rd  = r;
        e.mis = 1'b0;
        e.wr_en = 1'b0;
        if (sz == WORD && a[1:0] != 2'b00) begin
            e.mis = 1'b1;
        end else if (ld) begin
            exp_last = model_load(sz, a, rdata);
            e.wr_en  = wr;
        end
        e.data = exp_last;
        sb.push_back(e);
        n_wb_exp++;
    endtask

    // Memory side, entered in the first REQ cycle; returns in the write-back cycle.
    task automatic run_mem(input bit st, input logic [31:0] e_addr, input logic [31:0] e_be,
                           input logic [31:0] e_wdata, input int gw, input int rw,
                           input logic [31:0] rdata);
        int stalls = 0;
        for (int i = 0; i <= gw; i++) begin
            dmem_gnt_i = (i == gw);
            check("req", dmem_req_o, 1'b1);
            check("addr", dmem_addr_o, e_addr);
            check("be", dmem_be_o, e_be);
            check("we", dmem_we_o, st);
            if (st) check("wdata", dmem_wdata_o, e_wdata);
            stalls += int'(stall_o);
            tick();
        end
        dmem_gnt_i = 1'b0;
        if (!st) begin
            for (int i = 0; i <= rw; i++) begin
                dmem_rvalid_i = (i == rw);
                dmem_rdata_i  = (i == rw) ? rdata : $urandom;
                check("req_in_wait", dmem_req_o, 1'b0);
                stalls += int'(stall_o);
                tick();
            end
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = $urandom;
        end
        check("stall_cycles", 32'(stalls), st ? 32'(gw + 1) : 32'(gw + rw + 2));
        check("stall_wb_cycle", stall_o, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, stall_o, 1'b0);
        check({tag, "_req"}, dmem_req_o, 1'b0);
        check({tag, "_we"}, dmem_we_o, 1'b0);
        check({tag, "_addr"}, dmem_addr_o, 32'h0);
        check({tag, "_be"}, dmem_be_o, 4'h0);
        check({tag, "_wdata"}, dmem_wdata_o, 32'h0);
        check({tag, "_wb_valid"}, wb_valid_o, 1'b0);
        check({tag, "_wb_wr_en"}, wb_reg_wr_en_o, 1'b0);
        check({tag, "_wb_rd"}, wb_rd_o, 5'h0);
        check({tag, "_wb_data"}, wb_data_o, 32'h0);
        check({tag, "_misaligned"}, misaligned_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ea, eb, ew, ea2, eb2, ew2;
        bit ld;
        access_size_t sz;
        logic [31:0] a, rdv;
        rst_ni = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        reg_wr_en_i = 1'b0; access_size_i = BYTE; addr_i = '0; wdata_i = '0; rd_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        exp_last = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_ni = 1'b1;
        tick();

        // LW 0x100 -> rd5
        issue(1, 0, WORD, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF, ea, eb, ew);
        tick(); valid_i = 1'b0;
        run_mem(0, ea, eb, ew, 0, 0, 32'hDEADBEEF);
        check("t1_wb_valid", wb_valid_o, 1'b1);
        check("t1_wb_data", wb_data_o, 32'hDEADBEEF);
        check("t1_wb_rd", wb_rd_o, 5'd5);
        check("t1_wb_wr_en", wb_reg_wr_en_o, 1'b1);
        tick();

        // LB sign extension from two lanes of the same word
        issue(1, 0, BYTE, 32'h103, 32'h0, 5'd6, 1, 32'h80FFFF7F, ea, eb, ew);
        tick(); valid_i = 1'b0;
        run_mem(0, ea, eb, ew, 0, 0, 32'h80FFFF7F);
        check("t2_lb3", wb_data_o, 32'hFFFFFF80);
        tick();
        issue(1, 0, BYTE, 32'h100, 32'h0, 5'd7, 1, 32'h80FFFF7F, ea, eb, ew);
        tick(); valid_i = 1'b0;
        run_mem(0, ea, eb, ew, 0, 0, 32'h80FFFF7F);
        check("t2_lb0", wb_data_o, 32'h0000007F);
        tick();

        // SB 0x202
        issue(0, 1, BYTE, 32'h202, 32'h123456AB, 5'd8, 1, 32'h0, ea, eb, ew);
        tick(); valid_i = 1'b0;
        check("t3_addr", dmem_addr_o, 32'h200);
        check("t3_be", dmem_be_o, 4'b0100);
        check("t3_wdata", dmem_wdata_o, 32'hABABABAB);
        run_mem(1, ea, eb, ew, 0, 0, 32'h0);
        check("t3_wb_valid", wb_valid_o, 1'b1);
        check("t3_wb_wr_en", wb_reg_wr_en_o, 1'b0);
        tick();

        // Slow memory, with the next LW held on the inputs throughout
        issue(1, 0, WORD, 32'h400, 32'h0, 5'd9, 1, 32'hCAFEF00D, ea, eb, ew);
        tick();
        issue(1, 0, WORD, 32'h404, 32'h0, 5'd10, 1, 32'h01234567, ea2, eb2, ew2);
        run_mem(0, ea, eb, ew, 3, 3, 32'hCAFEF00D);
        check("t4_req_in_wb", dmem_req_o, 1'b0);
        tick(); valid_i = 1'b0;
        run_mem(0, ea2, eb2, ew2, 0, 0, 32'h01234567);
        tick();

        // Misaligned LW
        issue(1, 0, WORD, 32'h101, 32'h0, 5'd11, 1, 32'h0, ea, eb, ew);
        tick(); valid_i = 1'b0;
        check("t5_misaligned", misaligned_o, 1'b1);
        check("t5_wb_valid", wb_valid_o, 1'b1);
        check("t5_req", dmem_req_o, 1'b0);
        check("t5_stall", stall_o, 1'b0);
        tick();
        check("t5_mis_pulse", misaligned_o, 1'b0);
        check("t5_req_after", dmem_req_o, 1'b0);

        // Valid without load/store is ignored
        valid_i = 1'b1; is_load_i = 1'b0; is_store_i = 1'b0;
        tick(); valid_i = 1'b0;
        check("noop_req", dmem_req_o, 1'b0);
        check("noop_stall", stall_o, 1'b0);
        tick();

        // Load and store both set: behaves as a load
        issue(1, 1, WORD, 32'h500, 32'hFFFFFFFF, 5'd12, 1, 32'h55AA55AA, ea, eb, ew);
        tick(); valid_i = 1'b0;
        run_mem(0, ea, eb, ew, 1, 0, 32'h55AA55AA);
        tick();

        for (int i = 0; i < 8; i++) begin
            ld  = 1'($urandom_range(0, 1));
            sz  = access_size_t'(1'($urandom_range(0, 1)));
            a   = 32'($urandom_range(0, 4095));
            if (sz == WORD) a[1:0] = 2'b00;
            rdv = $urandom;
            issue(ld, !ld, sz, a, $urandom, 5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)),
                  rdv, ea, eb, ew);
            tick(); valid_i = 1'b0;
            run_mem(!ld, ea, eb, ew, $urandom_range(0, 2), $urandom_range(0, 2), rdv);
            if (i[0]) tick();
        end
        tick();

        // Reset while waiting for rvalid; the late rvalid must be ignored
        issue(1, 0, WORD, 32'h600, 32'h0, 5'd13, 1, 32'h0, ea, eb, ew);
        tick(); valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        check("t6_req", dmem_req_o, 1'b1);
        tick(); dmem_gnt_i = 1'b0;
        check("t6_wait_stall", stall_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_zero("t6_reset");
        void'(sb.pop_back());
        n_wb_exp--;
        exp_last = '0;
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD0BAD0;
        tick();
        dmem_rvalid_i = 1'b0;
        check("t6_stall_after", stall_o, 1'b0);
        check("t6_req_after", dmem_req_o, 1'b0);
        repeat (2) tick();
        check("t6_wb_data", wb_data_o, 32'h0);

        // Recovery after reset
        issue(1, 0, BYTE, 32'h702, 32'h0, 5'd14, 1, 32'h00770000, ea, eb, ew);
        tick(); valid_i = 1'b0;
        run_mem(0, ea, eb, ew, 0, 1, 32'h00770000);
        check("t7_wb_data", wb_data_o, 32'h00000077);
        repeat (3) tick();

        check("sb_empty", sb.size(), 32'h0);
        check("wb_count", n_wb, n_wb_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the multi-cycle core; receiving end of the ALU stage's memory-request interface.
- Accepts a load or store from the ALU stage and performs it on the data-memory port using a req/gnt/rvalid handshake.
- Holds the ALU stage with stall_o while an access is in flight.
- Returns write-back data to the register file: LB is sign-extended, LW is a full word.

Parameters:
DATA_WIDTH, 32, data path width (lane logic fixed at 4 bytes)
ADDR_WIDTH, 32, address width
REGISTER_WIDTH, 5, destination register index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
valid_i  in  1  memory request from ALU stage valid
is_load_i  in  1  request is a load
is_store_i  in  1  request is a store
reg_wr_en_i  in  1  request writes rd
access_size_i  in  access_size_t  BYTE or WORD
addr_i  in  ADDR_WIDTH  ALU result, used as byte address
wdata_i  in  DATA_WIDTH  rs2 data for stores
rd_i  in  REGISTER_WIDTH  destination register
stall_o  out  1  stage busy, ALU stage must hold
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  DATA_WIDTH  write data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  DATA_WIDTH  read data
wb_valid_o  out  1  one-cycle completion pulse
wb_reg_wr_en_o  out  1  write rd this cycle
wb_rd_o  out  REGISTER_WIDTH  destination register
wb_data_o  out  DATA_WIDTH  load result
misaligned_o  out  1  one-cycle pulse, misaligned WORD access dropped

Behaviour:
Reset:
- All outputs are 0 and state is IDLE.
- Reset asserted mid-access aborts the access: no wb pulse, and any rvalid arriving later is ignored.

States:
- IDLE:
  - stall_o=0.
  - If valid_i & (is_load_i | is_store_i), latch addr, wdata, size, rd, reg_wr_en and load/store.
  - If access_size_i=WORD and addr_i[1:0]!=0: do not go to REQ. Next cycle pulse misaligned_o and wb_valid_o, with wb_reg_wr_en_o=0. Stay IDLE.
  - Otherwise go to REQ.
  - If valid_i is high with neither is_load_i nor is_store_i, the request is ignored.
  - If is_load_i and is_store_i are both high, the request is treated as a load.
- REQ:
  - stall_o=1, dmem_req_o=1.
  - addr, we, be and wdata stay stable until gnt.
  - On dmem_gnt_i:
    - Store: go to IDLE and pulse wb_valid_o next cycle with wb_reg_wr_en_o=0.
    - Load: go to WAIT.
- WAIT:
  - stall_o=1, dmem_req_o=0.
  - On dmem_rvalid_i, capture and format the data. Next cycle state is IDLE and wb_valid_o=1, wb_reg_wr_en_o = latched reg_wr_en, wb_data_o = formatted data.
- Memory ordering: rvalid never arrives in the cycle of gnt; rvalid in IDLE or REQ is ignored.

Lane rules:
- BYTE store: dmem_be_o = 1<<addr[1:0]; dmem_wdata_o = wdata[7:0] replicated to all 4 lanes.
- WORD store: dmem_be_o = 4'b1111.
- Loads: dmem_be_o = 4'b1111.
- BYTE load: select byte addr[1:0] of rdata and sign-extend from bit 7.
- WORD load: full word.

Output timing:
- wb_data_o holds its last value between pulses.
- wb_rd_o is valid only with wb_valid_o.

Latency:
- Accept at edge N. REQ runs from cycle N+1.
- Load with gnt in cycle N+1 and rvalid in N+2: wb_valid_o in N+3. stall_o is high in N+1 and N+2.
- Store with gnt in N+1: wb_valid_o in N+2.

Back-to-back:
- In the wb_valid_o cycle the state is already IDLE.
- A request held by the ALU stage is accepted in that same cycle.

Test Plan:
1. LW addr=0x100, rd=5. gnt in the first REQ cycle, rvalid one cycle later with rdata=0xDEADBEEF. Expect: dmem_addr_o=0x100, dmem_be_o=1111, dmem_we_o=0; stall_o high exactly 2 cycles; wb_valid_o pulse with wb_data_o=0xDEADBEEF, wb_rd_o=5, wb_reg_wr_en_o=1.
2. LB addr=0x103 with rdata=0x80FFFF7F, then LB addr=0x100. Expect 0xFFFFFF80 for the first and 0x0000007F for the second.
3. SB addr=0x202 with wdata=0x123456AB. Expect: dmem_addr_o=0x200, dmem_be_o=0100, dmem_wdata_o=0xABABABAB, dmem_we_o=1; wb_valid_o with wb_reg_wr_en_o=0.
4. gnt delayed 3 cycles, then rvalid delayed 4 cycles. Expect: req held with stable addr/be/wdata for the 3 cycles; stall_o high 3+1+4 cycles; exactly one wb pulse. A second LW held on the inputs is accepted in the wb cycle and issues req the next cycle.
5. LW addr=0x101. Expect: no dmem_req_o; misaligned_o and wb_valid_o pulse next cycle with wb_reg_wr_en_o=0; stall_o stays 0.
6. rst_ni low while in WAIT, then rvalid=1 after reset is released. Expect: all outputs 0 immediately; state IDLE; no wb_valid_o.
